rtc_bus_responder: RTL
======================

# rtc_bus_responder

Responder end of the multiplexed RTC parallel bus (active-low CS/WR/RD, A/D select, 8-bit shared address/data). Decodes address and data phases generated by the bus controller and holds a 16-byte register file: BCD seconds/minutes/hours plus general RAM. Reads return register contents on a separate output bus with an output-enable for the top-level tristate. Used as an on-chip RTC stand-in and as the loopback target for controller verification.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per seconds increment, minimum 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cs`  in  1  chip select, active low.
- `wr`  in  1  write strobe, active low.
- `rd`  in  1  read strobe, active low.
- `ad`  in  1  0 = address phase, 1 = data phase.
- `dat_in`  in  8  bus value from the controller.
- `dat_out`  out  8  read data.
- `dat_oe`  out  1  high while `dat_out` must drive the bus.
- `addr_q`  out  8  last latched address.
- `wr_done`  out  1  one-cycle pulse per completed register write.
- `prot_err`  out  1  one-cycle pulse per protocol violation.

## Operation
- Input stage: `cs`, `wr`, `rd`, `ad`, `dat_in` registered together (stage S). Edges are detected between S and its one-cycle-delayed copy (stage D).
- FSM states: IDLE, ADR, DWR, DRD.
  - IDLE: S shows cs=0, wr=0, ad=0 -> ADR. S shows cs=0, ad=1, wr=0 -> DWR. S shows cs=0, ad=1, rd=0 -> DRD.
  - ADR: rising edge of wr or cs -> latch S.dat_in into `addr_q` and return to IDLE.
  - DWR: rising edge of wr or cs -> write S.dat_in to `addr_q`, pulse `wr_done`, return to IDLE.
  - DRD: on cs or rd high in S -> IDLE.
- Violations: any of the following pulses `prot_err` for one cycle, ignores the access, and returns to IDLE.
  - rd=0 with ad=0.
  - wr=0 and rd=0 together.
  - ad changing while cs=0 inside ADR, DWR or DRD.
- Map:
  - 0x00 seconds, 0x01 minutes, 0x02 hours (BCD).
  - 0x03–0x0F RAM.
  - Addresses ≥ 0x10: writes are dropped (no `wr_done`), reads return 0x00.
- Timekeeping: a prescaler counts 0..TICK_DIV-1. On wrap it increments seconds.
  - Seconds or minutes ≥ 0x59, or hours ≥ 0x23 (8-bit unsigned compare), go to 0x00 and carry to the next register.
  - Otherwise, low nibble ≥ 9 -> low nibble = 0 and high nibble + 1; else low nibble + 1.
  - Hours wrap without carry.
- A host write to 0x00–0x02 takes priority over the tick in that cycle. The tick is discarded for all three registers and the prescaler restarts at 0.
- Reset values: all registers 0x00, `addr_q` 0x00, prescaler 0, FSM IDLE, `dat_out` 0x00, `dat_oe` 0, `wr_done` 0, `prot_err` 0.

## Timing
- Latency is measured from a pin change to the output, without the macro.
- Address and data capture: the register updates 2 cycles after the wr rising edge at the pin (stage S, then edge detect and write). `wr_done` is asserted in the same cycle as the update.
- Hold: `dat_in` must stay stable for ≥ 1 cycle after wr rises. The controller's Tdh = 1 satisfies this.
- Read:
  - `dat_oe` = 1 and `dat_out` = register value 2 cycles after rd falls with cs=0, ad=1.
  - Both return to 0 / 0x00 2 cycles after rd or cs rises.
  - `dat_out` is re-sampled every cycle while in DRD, so a tick during the read is visible.
- A new access may begin the cycle after the FSM returns to IDLE. Back-to-back address-then-data phases with ≥ 1 idle cycle between them need no gap.
- Reset asserted mid-access:
  - Next edge: outputs go to reset values and any pending write is lost.
  - After reset releases, a bus already low must first return cs high before a new access is accepted (IDLE waits for cs=1 in S).

## Configuration
- `RTC_RESP_SYNC_EN`: when defined, adds a two-flop synchronizer in front of stage S on `cs`, `wr`, `rd`, `ad`, `dat_in`. This allows an asynchronous controller, and every latency above grows by 2 cycles.
- When undefined, the bus must come from the `clk` domain and only stage S is present.

## Test plan
- Address 0x05, then write 0xA7 (AD low, WR pulse; then AD high, WR pulse) -> `addr_q`=0x05, reg5=0xA7, one `wr_done` 2 cycles after the second WR rise.
- Address 0x05, then read with RD low for 6 cycles -> `dat_oe`=1 and `dat_out`=0xA7 from cycle 2 until 2 cycles after RD rises, then 0/0x00.
- TICK_DIV=4, preload sec=0x59, min=0x59, hr=0x23 -> after 4 cycles all three read 0x00. Preload sec=0x09 -> next tick 0x10.
- Host write to 0x00 in the same cycle as a prescaler wrap -> seconds = written value, no increment, next tick exactly TICK_DIV cycles later.
- RD low with AD low, and WR/RD low together -> one `prot_err` pulse each, no register change, `dat_oe` stays 0.
- Reset pulse during the DWR phase with CS still low -> regs 0x00, no `wr_done`, no access accepted until CS goes high then low again.

Source files
------------

// File: rtl/rtc_bus_responder.sv
// Responder for the multiplexed RTC parallel bus with a 16-byte BCD time/RAM register file.
// Define RTC_RESP_SYNC_EN to put a two-flop synchronizer ahead of the input stage.
module rtc_bus_responder #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic       ad,
  input  logic [7:0] dat_in,
  output logic [7:0] dat_out,
  output logic       dat_oe,
  output logic [7:0] addr_q,
  output logic       wr_done,
  output logic       prot_err
);

  localparam int               CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ADR, DWR, DRD} state_t;

  // Returns {carry, next}; values at or past the limit wrap to 0x00 with carry.
  function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] lim);
    if (v >= lim)
      return {1'b1, 8'h00};
    else if (v[3:0] >= 4'd9)
      return {1'b0, v[7:4] + 4'd1, 4'h0};
    else
      return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [11:0] bus_src;

`ifdef RTC_RESP_SYNC_EN
  logic [11:0] sync_a;
  logic [11:0] sync_b;

  always_ff @(posedge clk) begin
    sync_a <= {cs, wr, rd, ad, dat_in};
    sync_b <= sync_a;
  end

  assign bus_src = sync_b;
`else
  assign bus_src = {cs, wr, rd, ad, dat_in};
`endif

  // ---- stage S (p0) and its delayed copy D (p1) ----
  logic [11:0] bus_p0;
  logic [2:0]  ctl_p1;

  always_ff @(posedge clk) begin
    bus_p0 <= bus_src;
    ctl_p1 <= {bus_p0[11], bus_p0[10], bus_p0[8]};
  end

  logic       s_cs, s_wr, s_rd, s_ad;
  logic [7:0] s_dat;
  logic       d_cs, d_wr, d_ad;
  logic       wr_rise, cs_rise, ad_chg, bad_combo;

  assign {s_cs, s_wr, s_rd, s_ad, s_dat} = bus_p0;
  assign {d_cs, d_wr, d_ad}              = ctl_p1;

  assign wr_rise   = s_wr & ~d_wr;
  assign cs_rise   = s_cs & ~d_cs;
  assign ad_chg    = s_ad ^ d_ad;
  assign bad_combo = ~s_cs & ((~s_rd & ~s_ad) | (~s_wr & ~s_rd));

  // ---- access decode / FSM ----
  state_t state, state_nx;
  logic   armed, armed_nx;
  logic   err, addr_ld, wr_cmp, rd_act;

  // armed drops on reset or violation so a bus still held low is ignored until cs returns high.
  always_comb begin
    state_nx = state;
    armed_nx = armed | s_cs;
    err      = 1'b0;
    addr_ld  = 1'b0;
    wr_cmp   = 1'b0;
    rd_act   = 1'b0;
    if (state == IDLE) begin
      if (armed && bad_combo)
        err = 1'b1;
      else if (armed && !s_cs && !s_wr && !s_ad)
        state_nx = ADR;
      else if (armed && !s_cs && s_ad && !s_wr)
        state_nx = DWR;
      else if (armed && !s_cs && s_ad && !s_rd) begin
        state_nx = DRD;
        rd_act   = 1'b1;
      end
    end else if (bad_combo || (!s_cs && ad_chg)) begin
      err = 1'b1;
    end else begin
      case (state)
        ADR: if (wr_rise || cs_rise) begin
          addr_ld  = 1'b1;
          state_nx = IDLE;
        end
        DWR: if (wr_rise || cs_rise) begin
          wr_cmp   = 1'b1;
          state_nx = IDLE;
        end
        DRD: if (s_cs || s_rd)
          state_nx = IDLE;
        else
          rd_act = 1'b1;
        default: state_nx = IDLE;
      endcase
    end
    if (err) begin
      state_nx = IDLE;
      armed_nx = 1'b0;
    end
  end

  // ---- register file and timekeeping ----
  logic [7:0]       rf [16];
  logic [CNT_W-1:0] cnt;
  logic             addr_ok, rf_we, time_wr, tick;
  logic [7:0]       rd_data;
  logic [8:0]       sec_s, min_s, hr_s;

  assign addr_ok = (addr_q[7:4] == 4'h0);
  assign rf_we   = wr_cmp & addr_ok;
  assign time_wr = rf_we & (addr_q[3:0] < 4'd3);
  assign rd_data = addr_ok ? rf[addr_q[3:0]] : 8'h00;
  assign tick    = (cnt == CNT_LAST);
  assign sec_s   = bcd_step(rf[0], 8'h59);
  assign min_s   = bcd_step(rf[1], 8'h59);
  assign hr_s    = bcd_step(rf[2], 8'h23);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      armed    <= 1'b0;
      addr_q   <= 8'h00;
      dat_out  <= 8'h00;
      dat_oe   <= 1'b0;
      wr_done  <= 1'b0;
      prot_err <= 1'b0;
      cnt      <= '0;
      for (int i = 0; i < 16; i++)
        rf[i] <= 8'h00;
    end else begin
      state    <= state_nx;
      armed    <= armed_nx;
      dat_oe   <= rd_act;
      dat_out  <= rd_act ? rd_data : 8'h00;
      wr_done  <= rf_we;
      prot_err <= err;
      if (addr_ld)
        addr_q <= s_dat;
      // A host write to any time register discards the tick and restarts the prescaler.
      if (time_wr || tick)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (tick && !time_wr) begin
        rf[0] <= sec_s[7:0];
        if (sec_s[8])
          rf[1] <= min_s[7:0];
        if (sec_s[8] && min_s[8])
          rf[2] <= hr_s[7:0];
      end
      if (rf_we)
        rf[addr_q[3:0]] <= s_dat;
    end
  end

endmodule
